seg7_scan_ctrl: RTL

//  Time-multiplexed scan controller for a bank of common-anode 7-seg digits on
//  one shared segment bus. Holds a double-buffered BCD frame, steps one digit
//  per slot with an anti-ghost blank gap and decodes BCD to segment codes.

---
 rtl/seg7_scan_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered BCD frame, blank gap per slot, per-digit blink.
// Optional decimal-point mask is enabled by defining SEG7_SCAN_DP_EN.
module seg7_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 6,
    parameter int unsigned SLOT_CYC     = 50000,
    parameter int unsigned BLANK_CYC    = 16,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      ld,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
`ifdef SEG7_SCAN_DP_EN
    input  logic [NUM_DIGITS-1:0]     dp_mask,
`endif
    output logic                      pending,
    output logic                      frame_tick,
    output logic [7:0]                seg,
    output logic [NUM_DIGITS-1:0]     dig_n
);

    localparam int unsigned CNT_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned BF_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t                    r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [IDX_W-1:0]          r_idx;
    logic                      r_hold;
    logic [4*NUM_DIGITS-1:0]   r_stage;
    logic [4*NUM_DIGITS-1:0]   r_shadow;
    logic                      r_pending;
    logic [BF_W-1:0]           r_bfc;
    logic                      r_phase;
    logic                      r_frame_tick;
    logic [7:0]                r_seg;
    logic [NUM_DIGITS-1:0]     r_dig_n;

    state_t                    w_nxt_state;
    logic [CNT_W-1:0]          w_nxt_cnt;
    logic [IDX_W-1:0]          w_nxt_idx;
    logic [4*NUM_DIGITS-1:0]   w_nxt_shadow;
    logic                      w_nxt_pending;
    logic [BF_W-1:0]           w_nxt_bfc;
    logic                      w_nxt_phase;
    logic                      w_last_cyc;
    logic                      w_last_dig;
    logic                      w_boundary;
    logic [3:0]                w_digit;
    logic                      w_dark;
    logic                      w_dp_bit;
    logic [7:0]                w_nxt_seg;
    logic [NUM_DIGITS-1:0]     w_nxt_dig_n;

`ifdef SEG7_SCAN_DP_EN
    logic [NUM_DIGITS-1:0]     r_dp_stage;
    logic [NUM_DIGITS-1:0]     r_dp_shadow;
    logic [NUM_DIGITS-1:0]     w_nxt_dp_shadow;
`endif

    // Active-low {a,b,c,d,e,f,g}; codes 10..15 blank the digit.
    function automatic logic [6:0] f_decode(input logic [3:0] bcd);
        logic [6:0] code;
        case (bcd)
            4'd0:    code = 7'h01;
            4'd1:    code = 7'h4F;
            4'd2:    code = 7'h12;
            4'd3:    code = 7'h06;
            4'd4:    code = 7'h4C;
            4'd5:    code = 7'h24;
            4'd6:    code = 7'h20;
            4'd7:    code = 7'h0F;
            4'd8:    code = 7'h00;
            4'd9:    code = 7'h04;
            default: code = 7'h7F;
        endcase
        return code;
    endfunction

    always_comb begin
        w_last_cyc  = (r_cnt == CNT_W'(SLOT_CYC - 1));
        w_last_dig  = (r_idx == IDX_W'(NUM_DIGITS - 1));
        // A held scan (after en=0) restarts with a frame boundary on its first enabled edge.
        w_boundary  = en && (r_hold || (w_last_cyc && w_last_dig));

        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt + 1'b1;
        w_nxt_idx   = r_idx;
        if (!en || r_hold) begin
            w_nxt_state = ST_BLANK;
            w_nxt_cnt   = '0;
            w_nxt_idx   = '0;
        end else begin
            case (r_state)
                ST_BLANK: begin
                    if (r_cnt == CNT_W'(BLANK_CYC - 1)) begin
                        w_nxt_state = ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (w_last_cyc) begin
                        w_nxt_state = ST_BLANK;
                        w_nxt_cnt   = '0;
                        w_nxt_idx   = w_last_dig ? '0 : r_idx + 1'b1;
                    end
                end
                default: begin
                    w_nxt_state = ST_BLANK;
                    w_nxt_cnt   = '0;
                    w_nxt_idx   = '0;
                end
            endcase
        end

        w_nxt_shadow  = r_shadow;
        w_nxt_pending = r_pending;
        w_nxt_bfc     = r_bfc;
        w_nxt_phase   = r_phase;
        if (w_boundary) begin
            w_nxt_shadow  = ld ? digits_in : (r_pending ? r_stage : r_shadow);
            w_nxt_pending = 1'b0;
            if (r_bfc == BF_W'(BLINK_FRAMES - 1)) begin
                w_nxt_bfc   = '0;
                w_nxt_phase = ~r_phase;
            end else begin
                w_nxt_bfc   = r_bfc + 1'b1;
            end
        end else if (ld) begin
            w_nxt_pending = 1'b1;
        end

`ifdef SEG7_SCAN_DP_EN
        w_nxt_dp_shadow = r_dp_shadow;
        if (w_boundary) begin
            w_nxt_dp_shadow = ld ? dp_mask : (r_pending ? r_dp_stage : r_dp_shadow);
        end
        w_dp_bit = ~w_nxt_dp_shadow[w_nxt_idx];
`else
        w_dp_bit = 1'b1;
`endif

        // Outputs are computed from next-state values so they change on the same edge as state/idx.
        w_digit     = w_nxt_shadow[{w_nxt_idx, 2'b00} +: 4];
        w_dark      = (w_nxt_state == ST_BLANK) || (w_nxt_phase && blink_mask[w_nxt_idx]);
        w_nxt_seg   = w_dark ? 8'hFF : {w_dp_bit, f_decode(w_digit)};
        w_nxt_dig_n = w_dark ? '1 : ~(NUM_DIGITS'(1) << w_nxt_idx);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_BLANK;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_hold       <= 1'b0;
            r_stage      <= '1;
            r_shadow     <= '1;
            r_pending    <= 1'b0;
            r_bfc        <= '0;
            r_phase      <= 1'b0;
            r_frame_tick <= 1'b0;
            r_seg        <= 8'hFF;
            r_dig_n      <= '1;
        end else begin
            r_state      <= w_nxt_state;
            r_cnt        <= w_nxt_cnt;
            r_idx        <= w_nxt_idx;
            r_hold       <= ~en;
            if (ld) begin
                r_stage  <= digits_in;
            end
            r_shadow     <= w_nxt_shadow;
            r_pending    <= w_nxt_pending;
            r_bfc        <= w_nxt_bfc;
            r_phase      <= w_nxt_phase;
            r_frame_tick <= w_boundary;
            r_seg        <= w_nxt_seg;
            r_dig_n      <= w_nxt_dig_n;
        end
    end

`ifdef SEG7_SCAN_DP_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dp_stage  <= '0;
            r_dp_shadow <= '0;
        end else begin
            if (ld) begin
                r_dp_stage <= dp_mask;
            end
            r_dp_shadow <= w_nxt_dp_shadow;
        end
    end
`endif

    assign pending    = r_pending;
    assign frame_tick = r_frame_tick;
    assign seg        = r_seg;
    assign dig_n      = r_dig_n;

endmodule
